// File: rtl/audio_pkg.sv
// Shared defaults, state encodings and saturation limits for the drum voice
// scheduler and its per-voice channels.
package audio_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 24;

  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef enum logic {
    V_IDLE = 1'b0,
    V_PLAY = 1'b1
  } voice_state_t;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WAIT1 = 2'd1,
    M_WAIT2 = 2'd2
  } mix_state_t;

endpackage

// File: rtl/drum_voice_channel.sv
// One drum voice: trigger edge detector, play/idle state and ROM address
// counter that steps once per sample tick and stops after the last word.
module drum_voice_channel
  import audio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              trig_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              active_o
);

  logic              trig_prev_q;
  voice_state_t      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              trig_edge;

  // Previous-trigger resets high so a pad held through reset does not fire.
  assign trig_edge = trig_i & ~trig_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_prev_q <= 1'b1;
      state_q     <= V_IDLE;
      addr_q      <= '0;
    end else begin
      trig_prev_q <= trig_i;
      if (trig_edge) begin
        addr_q  <= '0;
        state_q <= V_PLAY;
      end else if (tick_i && state_q == V_PLAY) begin
        if (addr_q == '1) begin
          addr_q  <= '0;
          state_q <= V_IDLE;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign addr_o   = addr_q;
  assign active_o = (state_q == V_PLAY);

endmodule

// File: rtl/drum_voice_scheduler.sv
// Drum voice scheduler: sample-tick detection, per-voice channels, ROM fetch
// timing, saturating mixer and valid/ready hand-off to the codec.
module drum_voice_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_SHIFT = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         audio_clk,
  input  logic [NUM_VOICES-1:0]        trig,
  output logic [NUM_VOICES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_VOICES*DATA_W-1:0] rom_q,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic signed [DATA_W-1:0]     mix_data,
  output logic                         mix_valid,
  input  logic                         mix_ready,
  output logic                         overrun
);

  localparam int SUM_W = DATA_W + 2 + GAIN_SHIFT;
  localparam logic signed [SUM_W-1:0] SUM_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SUM_MAX)      return SUM_MAX[DATA_W-1:0];
    else if (s < SUM_MIN) return SUM_MIN[DATA_W-1:0];
    else                  return s[DATA_W-1:0];
  endfunction

  logic       audio_clk_prev_q;
  logic       tick_p0;
  mix_state_t mix_state_q;

  assign tick_p0 = audio_clk & ~audio_clk_prev_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    drum_voice_channel #(.ADDR_W(ADDR_W)) u_channel (
      .clk_i    (CLOCK_50),
      .rst_i    (reset),
      .tick_i   (tick_p0),
      .trig_i   (trig[v]),
      .addr_o   (rom_addr[v*ADDR_W +: ADDR_W]),
      .active_o (voice_active[v])
    );
  end

  // Stage p2: ROM data for the post-tick addresses is on rom_q; idle voices are muted.
  logic signed [SUM_W-1:0] sum_p2;
  logic signed [SUM_W-1:0] gained_p2;

  always_comb begin
    sum_p2 = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_active[v])
        sum_p2 = sum_p2 + SUM_W'(signed'(rom_q[v*DATA_W +: DATA_W]));
    end
    gained_p2 = sum_p2 <<< GAIN_SHIFT;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      audio_clk_prev_q <= 1'b1;
      mix_state_q      <= M_IDLE;
      mix_data         <= '0;
      mix_valid        <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      audio_clk_prev_q <= audio_clk;
      case (mix_state_q)
        M_IDLE:  if (tick_p0) mix_state_q <= M_WAIT1;
        M_WAIT1: mix_state_q <= M_WAIT2;
        M_WAIT2: mix_state_q <= M_IDLE;
        default: mix_state_q <= M_IDLE;
      endcase
      // A new sample wins over a same-cycle transfer; overwriting an unsent one is flagged.
      if (mix_state_q == M_WAIT2) begin
        mix_data  <= saturate(gained_p2);
        mix_valid <= 1'b1;
        if (mix_valid && !mix_ready) overrun <= 1'b1;
      end else if (mix_valid && mix_ready) begin
        mix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Self-checking bench for drum_voice_scheduler with a registered ROM stub and
// an event-level voice/mix reference model.
module tb_drum_voice_scheduler;

  localparam int NV = 4;
  localparam int AW = 13;
  localparam int DW = 24;
  localparam int LAST = (1 << AW) - 1;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset = 1'b1;
  logic                 audio_clk = 1'b1;
  logic                 mix_ready = 1'b1;
  logic [NV-1:0]        trig = '1;
  logic [NV*AW-1:0]     rom_addr;
  logic [NV*DW-1:0]     rom_q;
  logic [NV-1:0]        voice_active;
  logic signed [DW-1:0] mix_data;
  logic                 mix_valid;
  logic                 overrun;

  int n_cmp = 0;
  int n_mis = 0;
  int rom_base[NV];
  int rom_step[NV];
  bit m_play[NV];
  int m_pos[NV];

  drum_voice_scheduler dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .audio_clk    (audio_clk),
    .trig         (trig),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .voice_active (voice_active),
    .mix_data     (mix_data),
    .mix_valid    (mix_valid),
    .mix_ready    (mix_ready),
    .overrun      (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [DW-1:0] rom_word(int v, int a);
    return DW'(rom_base[v] + a * rom_step[v]);
  endfunction

  always @(posedge CLOCK_50)
    for (int v = 0; v < NV; v++)
      rom_q[v*DW +: DW] <= rom_word(v, int'(rom_addr[v*AW +: AW]));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_play[v] = 1'b0;
      m_pos[v]  = 0;
    end
  endtask

  task automatic model_trig(input logic [NV-1:0] mask);
    for (int v = 0; v < NV; v++)
      if (mask[v]) begin
        m_play[v] = 1'b1;
        m_pos[v]  = 0;
      end
  endtask

  task automatic model_tick();
    for (int v = 0; v < NV; v++)
      if (m_play[v]) begin
        if (m_pos[v] == LAST) begin
          m_pos[v]  = 0;
          m_play[v] = 1'b0;
        end else begin
          m_pos[v]++;
        end
      end
  endtask

  function automatic logic [NV*AW-1:0] exp_addr();
    logic [NV*AW-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v*AW +: AW] = AW'(m_pos[v]);
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_active();
    logic [NV-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_play[v];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_mix();
    longint s;
    logic signed [DW-1:0] w;
    s = 0;
    for (int v = 0; v < NV; v++)
      if (m_play[v]) begin
        w = rom_word(v, m_pos[v]);
        s += w;
      end
    s = s * 2;
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return DW'(s);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trig = '0;
    audio_clk = 1'b1;
    step(2);
    reset = 1'b0;
    model_clear();
    step(1);
  endtask

  task automatic trig_pulse(input logic [NV-1:0] mask);
    trig = mask;
    model_trig(mask);
    step(1);
    trig = '0;
    step(1);
  endtask

  // Leaves the bench one cycle after the tick cycle; tmask fires in the tick cycle.
  task automatic do_tick(input logic [NV-1:0] tmask);
    audio_clk = 1'b0;
    step(1);
    audio_clk = 1'b1;
    trig = tmask;
    model_tick();
    model_trig(tmask);
    step(1);
    trig = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int v = 0; v < NV; v++) begin
      rom_base[v] = 0;
      rom_step[v] = 0;
    end
    model_clear();

    reset = 1'b1; audio_clk = 1'b1; trig = '1;
    step(3);
    reset = 1'b0;
    step(1);
    check_eq("rst_addr", rom_addr, '0);
    check_eq("rst_active", voice_active, '0);
    check_eq("rst_data", unsigned'(mix_data), '0);
    check_eq("rst_valid", mix_valid, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    repeat (3) begin
      step(4);
      check_eq("held_valid", mix_valid, 1'b0);
      check_eq("held_active", voice_active, '0);
    end

    trig = '0;
    step(1);
    trig_pulse(4'b1000);
    repeat (3) begin
      do_tick('0);
      step(3);
    end
    check_eq("v3_addr_vec", rom_addr, exp_addr());
    check_eq("v3_addr", rom_addr[3*AW +: AW], 13'd3);
    check_eq("v3_active", voice_active, 4'b1000);
    do_tick(4'b1000);
    check_eq("retrig_addr", rom_addr, '0);
    check_eq("retrig_active", voice_active, 4'b1000);
    step(3);

    do_reset();
    for (int v = 0; v < NV; v++) rom_base[v] = v * 1000;
    trig_pulse(4'b0110);
    do_tick('0);
    step(1);
    check_eq("lat_t2_valid", mix_valid, 1'b0);
    step(1);
    check_eq("lat_t3_valid", mix_valid, 1'b1);
    check_eq("mix_6000", unsigned'(mix_data), 24'd6000);
    check_eq("mix_model", unsigned'(mix_data), exp_mix());
    step(1);
    check_eq("xfer_clear", mix_valid, 1'b0);

    do_reset();
    for (int v = 0; v < NV; v++) rom_base[v] = 32'h0060_0000;
    trig_pulse(4'b1111);
    do_tick('0);
    step(2);
    check_eq("sat_pos", unsigned'(mix_data), 24'h7FFFFF);
    for (int v = 0; v < NV; v++) rom_base[v] = 32'h00A0_0000;
    step(2);
    do_tick('0);
    step(2);
    check_eq("sat_neg", unsigned'(mix_data), 24'h800000);
    check_eq("sat_neg_model", unsigned'(mix_data), exp_mix());

    do_reset();
    for (int v = 0; v < NV; v++) rom_base[v] = 0;
    trig_pulse(4'b0001);
    repeat (LAST) do_tick('0);
    check_eq("end_addr", rom_addr[AW-1:0], 13'd8191);
    check_eq("end_active", voice_active, 4'b0001);
    do_tick('0);
    check_eq("wrap_addr", rom_addr, '0);
    check_eq("wrap_active", voice_active, 4'b0000);
    check_eq("wrap_model", voice_active, exp_active());
    step(3);

    do_reset();
    mix_ready = 1'b0;
    for (int v = 0; v < NV; v++) rom_base[v] = (v + 1) * 100;
    trig_pulse(4'b1111);
    do_tick('0);
    step(2);
    check_eq("ovr_first_valid", mix_valid, 1'b1);
    check_eq("ovr_first_data", unsigned'(mix_data), exp_mix());
    check_eq("ovr_not_yet", overrun, 1'b0);
    rom_base[0] = 5000;
    step(2);
    do_tick('0);
    step(2);
    check_eq("ovr_flag", overrun, 1'b1);
    check_eq("ovr_second_data", unsigned'(mix_data), exp_mix());
    check_eq("ovr_valid", mix_valid, 1'b1);
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_addr", rom_addr, '0);
    check_eq("mid_rst_active", voice_active, '0);
    check_eq("mid_rst_data", unsigned'(mix_data), '0);
    check_eq("mid_rst_valid", mix_valid, 1'b0);
    check_eq("mid_rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    mix_ready = 1'b1;
    model_clear();
    step(1);

    do_reset();
    for (int v = 0; v < NV; v++) begin
      rom_base[v] = int'($urandom & 32'h00FF_FFFF);
      rom_step[v] = int'($urandom_range(0, 4000)) - 2000;
    end
    for (int i = 0; i < 40; i++) begin
      logic [NV-1:0] m;
      m = NV'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) trig_pulse(m);
      do_tick(($urandom_range(0, 3) == 0) ? NV'($urandom_range(0, 15)) : '0);
      check_eq("rnd_addr", rom_addr, exp_addr());
      check_eq("rnd_active", voice_active, exp_active());
      step(2);
      check_eq("rnd_valid", mix_valid, 1'b1);
      check_eq("rnd_data", unsigned'(mix_data), exp_mix());
      step(1);
      check_eq("rnd_clear", mix_valid, 1'b0);
    end
    check_eq("rnd_overrun", overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/drum_voice_scheduler.md
Name: drum_voice_scheduler

Overview:
- Sequences the drum-sample ROM voices. Each voice has one ROM.
- Turns trigger inputs into per-voice play/stop state and ROM address counters, advanced once per sample tick.
- Fetches and mixes all voice samples into one saturated stream, handed to the codec write path with a valid/ready handshake.
- Sits between the pad/key inputs, the clock_divider sample clock, the audio_rom instances and the codec write interface.

Parameters:
- NUM_VOICES, 4: number of sample voices/ROMs.
- ADDR_W, 13: ROM address width; sample length is 2**ADDR_W words.
- DATA_W, 24: signed sample width at ROM output and mix output.
- GAIN_SHIFT, 1: left shift applied to the mix sum before saturation.

Ports:
- CLOCK_50 in 1: system clock; all logic on the rising edge.
- reset in 1: synchronous, active-high reset.
- audio_clk in 1: sample-rate square wave (divided clock); its rising edge is the sample tick.
- trig in NUM_VOICES: active-high voice triggers (top level inverts KEY); a rising edge starts the voice.
- rom_addr out NUM_VOICES*ADDR_W: per-voice ROM address; voice i is in bits [i*ADDR_W +: ADDR_W]; registered.
- rom_q in NUM_VOICES*DATA_W: signed ROM data, valid one cycle after the address is clocked into the ROM.
- voice_active out NUM_VOICES: 1 while the voice is in V_PLAY.
- mix_data out DATA_W: signed, saturated mixed sample.
- mix_valid out 1: mix_data holds an untransferred sample.
- mix_ready in 1: codec write_ready.
- overrun out 1: sticky flag; set when a pending sample is overwritten; cleared only by reset.

Behaviour:
- Reset: rom_addr=0, voice_active=0, mix_data=0, mix_valid=0, overrun=0. Mix FSM goes to M_IDLE.
- Edge-detect registers reset to 1 (audio_clk_prev=1, trig_prev=all-ones). An input held high through reset release gives no event.
- tick = audio_clk & ~audio_clk_prev. trig_edge[i] = trig[i] & ~trig_prev[i]. All edges are in the same cycle T.
- Voice FSM per voice, states V_IDLE and V_PLAY:
  - trig_edge: addr<=0, state<=V_PLAY. This applies from any state, so it is also a retrigger. It beats a simultaneous tick, giving addr=0.
  - tick in V_PLAY with addr != 2**ADDR_W-1: addr<=addr+1.
  - tick in V_PLAY with addr == 2**ADDR_W-1: addr<=0, state<=V_IDLE.
  - V_IDLE: addr is held at 0.
- Mix FSM, states M_IDLE, M_WAIT1, M_WAIT2:
  - T: M_IDLE->M_WAIT1 on tick. New addresses are visible from T+1.
  - T+1: ->M_WAIT2. The ROM registers the address at the end of T+1.
  - T+2: sample rom_q and form the sum; ->M_IDLE. mix_valid=1 from T+3.
- Sum rules:
  - Width DATA_W+2+GAIN_SHIFT, signed.
  - A voice in V_IDLE, judged at T+2, contributes 0.
  - The sum is shifted left by GAIN_SHIFT, then clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Handshake:
  - A transfer occurs in any cycle with mix_valid & mix_ready; mix_valid clears the next cycle.
  - A latch at T+2 in the same cycle as a transfer keeps mix_valid=1 with the new data.
  - A latch while mix_valid=1 and mix_ready=0 overwrites mix_data and sets overrun.
- A tick arriving while the mix FSM is not in M_IDLE is ignored for mixing; voice counters still advance. Unreachable at 44.1 kHz, but defined.
- Reset mid-play returns all state to its reset values on the next edge.

Decomposition:
- Package audio_pkg holds NUM_VOICES, ADDR_W and DATA_W defaults.
- It also holds voice_state_t {V_IDLE, V_PLAY}, mix_state_t {M_IDLE, M_WAIT1, M_WAIT2}, and the saturation limit constants.
- Sub-module drum_voice_channel holds one voice FSM, its address counter and trigger edge detector. It is instantiated NUM_VOICES times in a generate loop.
- The top level owns tick detection, the mix FSM, the adder/saturator and the handshake.

Test Plan:
- Reset with audio_clk=1 and trig=4'b1111 held, then release -> no voice starts, rom_addr all 0, mix_valid=0 across 3 ticks.
- trig[3] pulse, then 3 ticks -> rom_addr[3]=3, voice_active=4'b1000, other addrs 0. trig[3] coincident with a 4th tick -> rom_addr[3]=0, stays active.
- ROM stub with rom_q[i]=i*1000 and a 1-cycle latency model; voices 1 and 2 active; tick at cycle T -> mix_valid rises at T+3, mix_data=6000, mix_ready=1 clears it at T+4.
- All four rom_q=0x600000 -> mix_data=0x7FFFFF. All four 0xA00000 -> 0x800000.
- Voice 0 runs 8191 ticks -> addr=8191, active. Tick 8192 -> addr=0, voice_active[0]=0.
- mix_ready=0 across two ticks -> overrun=1, mix_data equals the second sample. Assert reset mid-play -> all outputs 0 next cycle.
